// File: rtl/mult_div_unit_pkg.sv
// Purpose : shared definitions for the multiply/divide unit -- word size,
//           iteration count, operation encodings and FSM state encoding.
// Ports   : none (package).
package mips_pkg;

    localparam int WORD      = 32;
    localparam int MDU_ITERS = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } mdu_state_e;

    // Magnitude of a word; unsigned operands pass through untouched.
    function automatic logic [WORD-1:0] mag_word(input logic [WORD-1:0] v, input logic is_signed);
        return (is_signed && v[WORD-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Purpose : request/result bundle between the pipeline and the multiply/divide unit.
// Signals : start, op[2:0], a, b, flush (pipeline -> unit);
//           busy, done, hi, lo (unit -> pipeline).
interface mdu_if;
    import mips_pkg::*;

    logic            start;
    logic [2:0]      op;
    logic [WORD-1:0] a;
    logic [WORD-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [WORD-1:0] hi;
    logic [WORD-1:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);

endinterface

// File: rtl/mult_div_unit_core.sv
// Purpose : iterative unsigned datapath. One step per enabled cycle:
//           radix-2 shift-add multiply or restoring shift-subtract divide.
//           After 32 steps o_hi:o_lo holds the product, or remainder:quotient.
// Ports   : clk, rst      - clock, async active-high reset
//           i_load        - capture operands magnitudes and operation kind
//           i_step        - perform one iteration
//           i_div         - 1 = divide, 0 = multiply (captured on i_load)
//           i_a, i_b      - unsigned operands
//           o_hi, o_lo    - upper/lower half of the working accumulator
module mdu_core
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_div,
    input  logic [WORD-1:0] i_a,
    input  logic [WORD-1:0] i_b,
    output logic [WORD-1:0] o_hi,
    output logic [WORD-1:0] o_lo
);

    logic [2*WORD-1:0] r_acc;
    logic [WORD-1:0]   r_b;
    logic              r_div;

    logic [WORD:0]     w_sum;
    logic [WORD:0]     w_rem_sh;
    logic [WORD-1:0]   w_diff;
    logic              w_ge;
    logic [2*WORD-1:0] w_acc_next;

    always_comb begin
        // Multiply: add b into the upper half when the current multiplier bit is 1,
        // then shift the 65-bit {carry, acc} right by one.
        w_sum    = {1'b0, r_acc[2*WORD-1:WORD]} + (r_acc[0] ? {1'b0, r_b} : {(WORD+1){1'b0}});
        // Divide: partial remainder in the upper half, dividend/quotient in the lower half.
        // The shifted remainder needs 33 bits before the compare.
        w_rem_sh = {r_acc[2*WORD-1:WORD], r_acc[WORD-1]};
        w_ge     = (w_rem_sh >= {1'b0, r_b});
        // Only used when w_ge, where the true difference is below 2^32.
        w_diff   = w_rem_sh[WORD-1:0] - r_b;
        if (r_div) begin
            w_acc_next = {(w_ge ? w_diff : w_rem_sh[WORD-1:0]), r_acc[WORD-2:0], w_ge};
        end else begin
            w_acc_next = {w_sum, r_acc[WORD-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_acc <= {{WORD{1'b0}}, i_a};
            r_b   <= i_b;
            r_div <= i_div;
        end else if (i_step) begin
            r_acc <= w_acc_next;
        end
    end

    assign o_hi = r_acc[2*WORD-1:WORD];
    assign o_lo = r_acc[WORD-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Purpose : MIPS-style HI/LO multiply/divide unit. Sequencing FSM, operand
//           sign capture, result sign correction and the HI/LO registers;
//           the iterative arithmetic lives in mdu_core.
// Ports   : clk, rst - clock, async active-high reset
//           bus      - mdu_if slave: start/op/a/b/flush in, busy/done/hi/lo out
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO are serviced here in one edge
// CALC  | 32 datapath iterations, one per cycle
// SIGN  | sign correction, done=1, HI/LO written at the closing edge
module mult_div_unit
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CALC = ST_CALC;
    localparam logic [1:0] S_SIGN = ST_SIGN;

    logic [1:0]      r_state;
    logic [5:0]      r_count;
    logic            r_div;
    logic            r_neg_a;
    logic            r_neg_b;
    logic            r_b_zero;
    logic [WORD-1:0] r_hi;
    logic [WORD-1:0] r_lo;

    logic              w_accept;
    logic              w_arith;
    logic              w_signed;
    logic              w_div;
    logic [WORD-1:0]   w_core_hi;
    logic [WORD-1:0]   w_core_lo;
    logic [2*WORD-1:0] w_prod;
    logic [WORD-1:0]   w_quo;
    logic [WORD-1:0]   w_rem;

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;
    assign w_arith  = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                      (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);

    mdu_core u_core (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept && w_arith),
        .i_step ((r_state == S_CALC) && !bus.flush),
        .i_div  (w_div),
        .i_a    (mag_word(bus.a, w_signed)),
        .i_b    (mag_word(bus.b, w_signed)),
        .o_hi   (w_core_hi),
        .o_lo   (w_core_lo)
    );

    // Operand sign flags are only set for signed ops, so unsigned results pass through.
    // A zero divisor yields an all-ones quotient from the core; force it regardless
    // of dividend sign. The remainder then equals |a| re-signed, i.e. a itself.
    always_comb begin
        w_prod = {w_core_hi, w_core_lo};
        if (r_neg_a ^ r_neg_b) begin
            w_prod = -w_prod;
        end
        w_quo = w_core_lo;
        if (r_b_zero) begin
            w_quo = '1;
        end else if (r_neg_a ^ r_neg_b) begin
            w_quo = -w_core_lo;
        end
        w_rem = r_neg_a ? -w_core_hi : w_core_hi;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_div    <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_b_zero <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_arith) begin
                            r_div    <= w_div;
                            r_neg_a  <= w_signed && bus.a[WORD-1];
                            r_neg_b  <= w_signed && bus.b[WORD-1];
                            r_b_zero <= (bus.b == '0);
                            r_count  <= '0;
                            r_state  <= S_CALC;
                        end else if (bus.op == OP_MTHI) begin
                            r_hi <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            r_lo <= bus.a;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else if (r_count == 6'(MDU_ITERS - 1)) begin
                        r_state <= S_SIGN;
                    end else begin
                        r_count <= r_count + 6'd1;
                    end
                end
                S_SIGN: begin
                    r_state <= S_IDLE;
                    if (!bus.flush) begin
                        if (r_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*WORD-1:WORD];
                            r_lo <= w_prod[WORD-1:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_SIGN) && !bus.flush;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
